// File: rtl/add_div_mix_pkg.sv
// Shared constants and FSM encodings for the add/div mix restoring divider.
package add_div_mix_pkg;

    localparam int unsigned ADM_W     = 4;
    localparam int unsigned ADM_QW    = 2 * ADM_W;
    localparam int unsigned ADM_CNT_W = $clog2(ADM_QW);

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/add_div_mix_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor,
// keep the difference when it does not borrow.
module add_div_mix_step
    import add_div_mix_pkg::*;
#(
    parameter int unsigned W = ADM_W
) (
    input  logic [W:0]   rem_cur,
    input  logic         bit_next,
    input  logic [W-1:0] divisor,
    output logic [W:0]   rem_next,
    output logic         q_bit
);

    logic [W:0] shifted;
    logic [W:0] diff;
    logic       borrow;

    // A set top bit means the shifted value exceeds any W-bit divisor, so the
    // truncated difference is still exact and the step must succeed.
    always_comb begin
        shifted       = {rem_cur[W-1:0], bit_next};
        {borrow, diff} = {1'b0, shifted} - {2'b00, divisor};
        q_bit         = rem_cur[W] | ~borrow;
        rem_next      = q_bit ? diff : shifted;
    end

endmodule

// File: rtl/add_div_mix_4_bit.sv
// Sequential divider recovering (a+b) = prod / ((c+d) mod 2^W), one quotient bit per clock.
// Optional ADD_DIV_MIX_DBZ_BYPASS_EN skips the iterations when the divisor is zero.
module add_div_mix_4_bit
    import add_div_mix_pkg::*;
#(
    parameter int unsigned W = ADM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   prod_i,
    input  logic [W-1:0]     c_i,
    input  logic [W-1:0]     d_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   quot_o,
    output logic [W-1:0]     rem_o,
    output logic             dbz_o
);

    localparam int unsigned QW = 2 * W;
    localparam int unsigned CW = $clog2(QW);

    state_t        state_q;
    state_t        state_d;
    logic [QW-1:0] div_q;
    logic [QW-1:0] quo_q;
    logic [W:0]    rem_q;
    logic [W-1:0]  s_q;
    logic          dbz_q;
    logic [CW-1:0] cnt_q;

    logic          accept;
    logic [W-1:0]  s_new;
    logic          s_zero;
    logic          handshake;
    logic [W:0]    step_rem;
    logic          step_q;

    assign accept    = in_valid & in_ready;
    assign s_new     = W'(c_i + d_i);
    assign s_zero    = (s_new == '0);
    assign handshake = out_valid & out_ready;

    add_div_mix_step #(.W(W)) u_step (
        .rem_cur  (rem_q),
        .bit_next (div_q[QW-1]),
        .divisor  (s_q),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef ADD_DIV_MIX_DBZ_BYPASS_EN
                    state_d = s_zero ? ST_DONE : ST_CALC;
`else
                    state_d = ST_CALC;
`endif
                end
            end
            ST_CALC: begin
                if (cnt_q == CW'(QW - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (handshake) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Working registers: operand capture and one restoring step per CALC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            s_q   <= '0;
            dbz_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        div_q <= prod_i;
                        s_q   <= s_new;
                        dbz_q <= s_zero;
                        quo_q <= '0;
                        rem_q <= '0;
                        cnt_q <= '0;
                    end
                end
                ST_CALC: begin
                    rem_q <= step_rem;
                    quo_q <= {quo_q[QW-2:0], step_q};
                    div_q <= {div_q[QW-2:0], 1'b0};
                    cnt_q <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Output registers: results are published on the first DONE cycle and held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quot_o    <= '0;
            rem_o     <= '0;
            dbz_o     <= 1'b0;
        end else begin
            in_ready <= (state_d == ST_IDLE);
            if (state_q == ST_DONE) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    quot_o    <= dbz_q ? '1 : quo_q;
                    rem_o     <= dbz_q ? '0 : rem_q[W-1:0];
                    dbz_o     <= dbz_q;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
